// File: rtl/bnn_weight_streamer_if.sv
// bnn_weight_streamer_if
//   Host write port and core-loader stream port of the BNN weight streamer,
//   bundled so the host/config side and the streamer share one connection.
//   Signals:
//     wr_en/wr_addr/wr_data : host byte write into the weight buffer
//     wr_reject             : one-cycle pulse, the previous write was ignored
//     start/stall           : begin a full stream / pause emission
//     wt_nibble/load_en     : nibble and its valid strobe to the core loader
//     busy/done             : streaming in progress / end-of-stream pulse
//   modport master : host side (drives writes, start, stall)
//   modport slave  : streamer side
interface bnn_weight_streamer_if #(
  parameter int ADDR_W   = 4,
  parameter int WEIGHT_W = 8
) ();
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [WEIGHT_W-1:0]   wr_data;
  logic                  wr_reject;
  logic                  start;
  logic                  stall;
  logic [WEIGHT_W/2-1:0] wt_nibble;
  logic                  load_en;
  logic                  busy;
  logic                  done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stall,
    input  wr_reject, wt_nibble, load_en, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stall,
    output wr_reject, wt_nibble, load_en, busy, done
  );
endinterface

// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer
//   Transmit side of the BNN nibble-serial weight-load path. Keeps a local
//   copy of every neuron weight byte and, on start, streams all of them
//   low nibble first, neuron 0..NUM_NEURONS-1, into the core loader.
//   Ports:
//     clk_i   : clock
//     reset_i : synchronous active-high reset; reloads the core power-on
//               weights so a start straight after reset replays them
//     ws_if   : slave modport of bnn_weight_streamer_if (host writes,
//               start/stall, nibble stream, busy/done, wr_reject)
//   All outputs are registered except busy, which is decoded from state.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int WEIGHT_W    = 8,
  parameter int ADDR_W      = 4,
  parameter logic [NUM_NEURONS-1:0][WEIGHT_W-1:0] DEFAULT_WTS = {
    8'h0F, 8'hF7, 8'h62, 8'hF9, 8'h3A, 8'h67,
    8'hB7, 8'hED, 8'h18, 8'h7A, 8'h41, 8'hA0
  }
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bnn_weight_streamer_if.slave  ws_if
);

  localparam int HALF    = WEIGHT_W / 2;
  localparam int NIB_CNT = 2 * NUM_NEURONS;
  localparam int NIB_W   = $clog2(NIB_CNT);
  localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(NIB_CNT - 1);
  localparam logic [ADDR_W:0]   NUM_N_EXT = (ADDR_W + 1)'(NUM_NEURONS);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

  typedef struct packed {
    logic                en;
    logic [ADDR_W-1:0]   addr;
    logic [WEIGHT_W-1:0] data;
  } wr_req_t;

  state_e                             state_q, state_d;
  logic [NIB_W-1:0]                   nib_idx_q, nib_idx_d;
  logic [HALF-1:0]                    nib_q, nib_d;
  logic                               load_en_q, load_en_d;
  logic                               done_q, done_d;
  logic                               wr_reject_q, wr_reject_d;
  logic [NUM_NEURONS-1:0][WEIGHT_W-1:0] buf_q, buf_d;

  wr_req_t             wr_req;
  logic                addr_ok;
  logic                wr_ok;
  logic [WEIGHT_W-1:0] rd_byte;

  assign wr_req  = '{en: ws_if.wr_en, addr: ws_if.wr_addr, data: ws_if.wr_data};
  assign addr_ok = {1'b0, wr_req.addr} < NUM_N_EXT;

  // Byte currently being serialized; nib_idx[0] picks the half.
  assign rd_byte = buf_q[nib_idx_q[NIB_W-1:1]];

  always_comb begin
    state_d     = state_q;
    nib_idx_d   = nib_idx_q;
    nib_d       = nib_q;
    load_en_d   = 1'b0;
    done_d      = 1'b0;
    buf_d       = buf_q;
    // Buffer is frozen while streaming so the core never sees a torn byte.
    wr_ok       = wr_req.en && addr_ok && (state_q != S_STREAM);
    wr_reject_d = wr_req.en && !wr_ok;
    if (wr_ok) buf_d[wr_req.addr] = wr_req.data;

    case (state_q)
      S_IDLE: begin
        if (ws_if.start) begin
          state_d   = S_STREAM;
          nib_idx_d = '0;
        end
      end
      S_STREAM: begin
        // On stall, nibble and index hold; the core keeps its half-byte.
        if (!ws_if.stall) begin
          nib_d     = nib_idx_q[0] ? rd_byte[WEIGHT_W-1:HALF] : rd_byte[HALF-1:0];
          load_en_d = 1'b1;
          if (nib_idx_q == NIB_LAST) begin
            state_d   = S_DONE;
            nib_idx_d = '0;
          end else begin
            nib_idx_d = nib_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      nib_idx_q   <= '0;
      nib_q       <= '0;
      load_en_q   <= 1'b0;
      done_q      <= 1'b0;
      wr_reject_q <= 1'b0;
      buf_q       <= DEFAULT_WTS;
    end else begin
      state_q     <= state_d;
      nib_idx_q   <= nib_idx_d;
      nib_q       <= nib_d;
      load_en_q   <= load_en_d;
      done_q      <= done_d;
      wr_reject_q <= wr_reject_d;
      buf_q       <= buf_d;
    end
  end

  assign ws_if.wt_nibble = nib_q;
  assign ws_if.load_en   = load_en_q;
  assign ws_if.done      = done_q;
  assign ws_if.wr_reject = wr_reject_q;
  assign ws_if.busy      = (state_q == S_STREAM);

endmodule
